// File: rtl/result_serializer_if.sv
// Beat stream from the result serializer toward the output pins.
// The master drives valid/byte/last; the slave answers with ready.
interface result_serializer_if #(
    parameter int OUT_W = 8
) ();
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [OUT_W-1:0] out_byte;

    modport master (
        output out_valid,
        output out_byte,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_byte,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/result_serializer.sv
// Captures NUM_WORDS result words plus a mode tag and emits a {SYNC,mode} header beat followed by payload beats.
// Define RESULT_SERIALIZER_CHECKSUM_EN to append an XOR check beat after the payload.
module result_serializer #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 2,
    parameter int OUT_W     = 8,
    parameter int MODE_W    = 3,
    parameter logic [OUT_W-MODE_W-1:0] SYNC = 5'b10110
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [MODE_W-1:0]           mode,
    input  logic [NUM_WORDS*WORD_W-1:0] words,
    output logic                        busy,
    output logic                        done,
    result_serializer_if.master         out_if
);
    localparam int BPW     = WORD_W / OUT_W;
    localparam int PAY     = NUM_WORDS * BPW;
    localparam int FRAME_W = NUM_WORDS * WORD_W;
    localparam int CNT_W   = (PAY > 1) ? $clog2(PAY) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAY - 1);

`ifdef RESULT_SERIALIZER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_CHECK, S_FIN} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_FIN} state_t;
`endif

    state_t             state_reg;
    logic [FRAME_W-1:0] frame_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [OUT_W-1:0]   out_byte_reg;
    logic               out_valid_reg;
    logic               out_last_reg;
    logic               busy_reg;
    logic               done_reg;
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
    logic [OUT_W-1:0]   xor_reg;
`endif

    // Word 0 goes to the top of the frame so the whole frame drains MSB-first.
    logic [FRAME_W-1:0] words_ordered;
    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_order
            assign words_ordered[(NUM_WORDS-1-gi)*WORD_W +: WORD_W] = words[gi*WORD_W +: WORD_W];
        end
    endgenerate

    logic [OUT_W-1:0] beat_top;
    assign beat_top = frame_reg[FRAME_W-1 -: OUT_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            frame_reg     <= '0;
            cnt_reg       <= '0;
            out_byte_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
            xor_reg       <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        frame_reg     <= words_ordered;
                        out_byte_reg  <= {SYNC, mode};
                        out_valid_reg <= 1'b1;
                        out_last_reg  <= 1'b0;
                        busy_reg      <= 1'b1;
                        cnt_reg       <= '0;
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
                        xor_reg       <= '0;
`endif
                        state_reg     <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (out_if.out_ready) begin
                        out_byte_reg <= beat_top;
                        frame_reg    <= frame_reg << OUT_W;
                        cnt_reg      <= '0;
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
                        out_last_reg <= 1'b0;
                        xor_reg      <= beat_top;
`else
                        out_last_reg <= (PAY == 1);
`endif
                        state_reg    <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (out_if.out_ready) begin
                        if (cnt_reg == LAST_CNT) begin
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
                            // xor_reg already folds in the beat being accepted now.
                            out_byte_reg <= xor_reg;
                            out_last_reg <= 1'b1;
                            state_reg    <= S_CHECK;
`else
                            out_valid_reg <= 1'b0;
                            out_byte_reg  <= '0;
                            out_last_reg  <= 1'b0;
                            busy_reg      <= 1'b0;
                            done_reg      <= 1'b1;
                            state_reg     <= S_FIN;
`endif
                        end else begin
                            out_byte_reg <= beat_top;
                            frame_reg    <= frame_reg << OUT_W;
                            cnt_reg      <= cnt_reg + CNT_W'(1);
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
                            out_last_reg <= 1'b0;
                            xor_reg      <= xor_reg ^ beat_top;
`else
                            out_last_reg <= ((cnt_reg + CNT_W'(1)) == LAST_CNT);
`endif
                        end
                    end
                end
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
                S_CHECK: begin
                    if (out_if.out_ready) begin
                        out_valid_reg <= 1'b0;
                        out_byte_reg  <= '0;
                        out_last_reg  <= 1'b0;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        state_reg     <= S_FIN;
                    end
                end
`endif
                S_FIN: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign out_if.out_valid = out_valid_reg;
    assign out_if.out_byte  = out_byte_reg;
    assign out_if.out_last  = out_last_reg;
    assign busy             = busy_reg;
    assign done             = done_reg;
endmodule

// File: tb/tb_result_serializer.sv
// Scoreboard bench for result_serializer: default 2x32-bit instance plus a 3x16-bit instance.
// Expected beats are queued by the stimulus and popped by per-instance monitors.
module tb_result_serializer;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, start2;
    logic [2:0]  mode, mode2;
    logic [63:0] words;
    logic [47:0] words2;
    logic        busy, done, busy2, done2;

    always #5 clk = ~clk;

`ifdef RESULT_SERIALIZER_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int LAT  = CHK ? 11 : 10;
    localparam int LAT2 = CHK ? 9 : 8;

    result_serializer_if #(.OUT_W(8)) ifc ();
    result_serializer_if #(.OUT_W(8)) ifc2 ();

    result_serializer dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .words(words),
        .busy(busy), .done(done), .out_if(ifc)
    );

    result_serializer #(.WORD_W(16), .NUM_WORDS(3), .OUT_W(8)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode2), .words(words2),
        .busy(busy2), .done(done2), .out_if(ifc2)
    );

    assign ifc2.out_ready = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] exp_q[$];
    logic [8:0] exp2_q[$];
    logic [8:0] e1, e2;

    typedef logic [7:0] beats9_t [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ifc.out_valid && ifc.out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL beat: got %02h last=%b, expected no beat", ifc.out_byte, ifc.out_last);
            end else begin
                e1 = exp_q.pop_front();
                $display("dut  beat %02h last=%b (expected %02h last=%b)", ifc.out_byte, ifc.out_last, e1[7:0], e1[8]);
                check("beat", 32'({ifc.out_last, ifc.out_byte}), 32'(e1));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ifc2.out_valid && ifc2.out_ready) begin
            if (exp2_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL beat2: got %02h last=%b, expected no beat", ifc2.out_byte, ifc2.out_last);
            end else begin
                e2 = exp2_q.pop_front();
                $display("dut2 beat %02h last=%b (expected %02h last=%b)", ifc2.out_byte, ifc2.out_last, e2[7:0], e2[8]);
                check("beat2", 32'({ifc2.out_last, ifc2.out_byte}), 32'(e2));
            end
        end
    end

    task automatic push_frame(input beats9_t b, input logic [7:0] chk);
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back({(i == 8) && !CHK, b[i]});
        end
        if (CHK) exp_q.push_back({1'b1, chk});
    endtask

    task automatic pulse_start(input logic [2:0] m, input logic [63:0] w);
        mode  = m;
        words = w;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int lat);
        int cyc = 1;
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("busy_at_done", 32'(busy), 32'd0);
            if (lat > 0) check("latency", 32'(cyc), 32'(lat));
            @(posedge clk); #1;
            check("done_width", 32'(done), 32'd0);
            check("queue_drained", 32'(exp_q.size()), 32'd0);
            $display("frame done after %0d cycles", cyc);
        end
    endtask

    task automatic wait_byte(input logic [7:0] b);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            if (ifc.out_valid && ifc.out_byte == b) seen = 1'b1;
        end
        check("reach_beat", 32'(seen), 32'd1);
    endtask

    initial begin
        bit done_flag;
        bit prev_busy;
        bit seen2;
        int cyc2;
        rst = 1'b1; start = 1'b0; mode = '0; words = '0;
        start2 = 1'b0; mode2 = '0; words2 = '0;
        ifc.out_ready = 1'b1;

        // Reset state
        @(posedge clk); #1;
        check("rst_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_byte", 32'(ifc.out_byte), 32'd0);
        check("rst_last", 32'(ifc.out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset mid-frame
        push_frame('{8'hB3, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 8'h01}, 8'h09);
        pulse_start(3'b011, {32'h00000001, 32'h12345678});
        wait_byte(8'h56);
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(ifc.out_valid), 32'd0);
        check("midrst_byte", 32'(ifc.out_byte), 32'd0);
        check("midrst_last", 32'(ifc.out_last), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        done_flag = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy || ifc.out_valid) done_flag = 1'b1;
        end
        check("no_done_after_rst", 32'(done_flag), 32'd0);

        // Basic frame with out_ready high, latency checked
        push_frame('{8'hB3, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 8'h01}, 8'h09);
        pulse_start(3'b011, {32'h00000001, 32'h12345678});
        wait_done(LAT);

        // Backpressure on beat 0x56
        push_frame('{8'hB3, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 8'h01}, 8'h09);
        pulse_start(3'b011, {32'h00000001, 32'h12345678});
        wait_byte(8'h56);
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("hold_byte", 32'(ifc.out_byte), 32'h56);
            check("hold_valid", 32'(ifc.out_valid), 32'd1);
        end
        ifc.out_ready = 1'b1;
        wait_done(0);

        // Start while busy is ignored; the later start sends new words
        push_frame('{8'hB3, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 8'h01}, 8'h09);
        pulse_start(3'b011, {32'h00000001, 32'h12345678});
        @(posedge clk); #1;
        pulse_start(3'b111, {32'hFFFFFFFF, 32'hFFFFFFFF});
        wait_done(0);
        push_frame('{8'hB5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hF0, 8'h0D}, 8'hEB);
        pulse_start(3'b101, {32'hCAFEF00D, 32'hDEADBEEF});
        wait_done(LAT);

        // 3 x 16-bit instance: 7 beats, busy falls with done
        exp2_q.push_back({1'b0, 8'hB3});
        exp2_q.push_back({1'b0, 8'h12});
        exp2_q.push_back({1'b0, 8'h34});
        exp2_q.push_back({1'b0, 8'hAB});
        exp2_q.push_back({1'b0, 8'hCD});
        exp2_q.push_back({1'b0, 8'h0F});
        exp2_q.push_back({!CHK, 8'h0F});
        if (CHK) exp2_q.push_back({1'b1, 8'h40});
        mode2  = 3'b011;
        words2 = {16'h0F0F, 16'hABCD, 16'h1234};
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        cyc2 = 1;
        seen2 = 1'b0;
        prev_busy = busy2;
        for (int i = 0; i < 50 && !seen2; i++) begin
            @(posedge clk); #1;
            cyc2++;
            if (done2) seen2 = 1'b1;
            else prev_busy = busy2;
        end
        check("done2_seen", 32'(seen2), 32'd1);
        check("busy2_before_done", 32'(prev_busy), 32'd1);
        check("busy2_at_done", 32'(busy2), 32'd0);
        check("latency2", 32'(cyc2), 32'(LAT2));
        @(posedge clk); #1;
        check("done2_width", 32'(done2), 32'd0);
        check("queue2_drained", 32'(exp2_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
